// File: rtl/fft64_frame_ctrl.sv
// fft64_frame_ctrl: frame sequencer for the 64-point radix-4 FFT core.
//   Collects 64 serial complex samples into an input buffer, presents the buffer to the
//   core's parallel inputs and holds it stable for the core latency, captures the 64
//   parallel results and streams them out in bin order 0..63.
//   Sample format: {re[31:16], im[15:0]}, two's complement Q5.11.
// Build option: define FFTCTL_INV_EN to add the `inv` port (re/im swap on input and output,
//   giving an unscaled inverse FFT through the forward core).
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   s_data/s_valid/s_ready  input sample stream; s_last marks the 64th sample
//   m_data/m_valid/m_ready  output bin stream; m_last marks bin 63
//   core_x                  to core inputs, sample k on [32k+31:32k]
//   core_f                  from core outputs, bin k on [32k+31:32k]
//   busy                    frame in progress
//   frame_err               one-cycle pulse on a framing error
//   inv                     (FFTCTL_INV_EN only) inverse select, sampled on first beat
module fft64_frame_ctrl #(
  parameter int unsigned LAT = 2,
  parameter int unsigned DW  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FFTCTL_INV_EN
  input  logic            inv,
`endif
  input  logic [DW-1:0]   s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [64*DW-1:0] core_x,
  input  logic [64*DW-1:0] core_f,
  output logic            busy,
  output logic            frame_err
);

  localparam int unsigned LatW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [LatW-1:0] LatMax = LatW'(LAT);
  localparam int unsigned HalfW = DW / 2;

  typedef enum logic [1:0] {StFill, StWait, StDrain} state_e;

  state_e                state_q;
  logic [5:0]            wcnt_q;
  logic [5:0]            rcnt_q;
  logic [LatW-1:0]       latcnt_q;
  logic [63:0][DW-1:0]   ibuf_q;
  logic [63:0][DW-1:0]   obuf_q;
  logic                  frame_err_q;

  logic                  inv_in;
  logic                  inv_out;
  logic [DW-1:0]         s_word;
  logic [DW-1:0]         o_word;

`ifdef FFTCTL_INV_EN
  logic inv_q;

  // The first beat of a frame must use the live pin; later beats use the held value.
  assign inv_in  = (wcnt_q == 6'd0) ? inv : inv_q;
  assign inv_out = inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (state_q == StFill && s_valid && wcnt_q == 6'd0) begin
      inv_q <= inv;
    end
  end
`else
  assign inv_in  = 1'b0;
  assign inv_out = 1'b0;
`endif

  assign s_word = inv_in ? {s_data[HalfW-1:0], s_data[DW-1:HalfW]} : s_data;
  assign o_word = obuf_q[rcnt_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      wcnt_q      <= 6'd0;
      rcnt_q      <= 6'd0;
      latcnt_q    <= '0;
      ibuf_q      <= '0;
      obuf_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (s_valid) begin
            if (wcnt_q == 6'd63) begin
              // 64th beat completes the frame even without s_last (flagged only).
              ibuf_q[wcnt_q] <= s_word;
              latcnt_q       <= '0;
              state_q        <= StWait;
              if (!s_last) begin
                frame_err_q <= 1'b1;
              end
            end else if (s_last) begin
              // Premature end: drop this beat and restart the frame.
              wcnt_q      <= 6'd0;
              frame_err_q <= 1'b1;
            end else begin
              ibuf_q[wcnt_q] <= s_word;
              wcnt_q         <= wcnt_q + 6'd1;
            end
          end
        end
        StWait: begin
          latcnt_q <= latcnt_q + 1'b1;
          if (latcnt_q == LatMax) begin
            obuf_q  <= core_f;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (m_ready) begin
            if (rcnt_q == 6'd63) begin
              rcnt_q  <= 6'd0;
              wcnt_q  <= 6'd0;
              state_q <= StFill;
            end else begin
              rcnt_q <= rcnt_q + 6'd1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign s_ready   = (state_q == StFill);
  assign m_valid   = (state_q == StDrain);
  assign m_last    = (state_q == StDrain) && (rcnt_q == 6'd63);
  assign m_data    = inv_out ? {o_word[HalfW-1:0], o_word[DW-1:HalfW]} : o_word;
  assign core_x    = ibuf_q;
  assign busy      = (state_q != StFill) || (wcnt_q != 6'd0);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Self-checking bench for fft64_frame_ctrl with an identity stub core (LAT registers).
module tb_fft64_frame_ctrl;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [2047:0] core_x;
  logic [2047:0] core_f;
  logic          busy;
  logic          frame_err;
`ifdef FFTCTL_INV_EN
  logic          inv = 1'b0;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int err_cycles = 0;
  int valid_cycles = 0;
  logic [31:0] stim [64];

  always #5 clk = ~clk;

  // Stub core: identity transform delayed by LAT register stages.
  logic [2047:0] d1, d2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= core_x;
      d2 <= d1;
    end
  end
  assign core_f = d2;

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (m_valid) valid_cycles++;
  end

  fft64_frame_ctrl #(.LAT(LAT), .DW(32)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FFTCTL_INV_EN
    .inv(inv),
`endif
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last(s_last),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .core_x(core_x),
    .core_f(core_f),
    .busy(busy),
    .frame_err(frame_err)
  );

  task automatic fill_random();
    for (int i = 0; i < 64; i++) stim[i] = $urandom;
  endtask

  // Sends stim[0..n-1]; s_last on index last_at (-1 for none).
  task automatic send_words(input int n, input int last_at, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = stim[i];
      s_last  = (i == last_at);
      guard = 0;
      while (!s_ready && guard < 500) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!s_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout beat=%0d s_ready=%b required 1", i, s_ready);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drains bins, expecting the identity of stim; mode 0 ready, 1 pattern 1001, 2 random.
  task automatic collect(input int mode, input int stop_at);
    int idx = 0;
    int guard = 0;
    int phase = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    while (idx < stop_at && guard < 3000) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (phase % 4 == 0) || (phase % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid) begin
        phase++;
        if (prev_stall) begin
          n_tests++;
          if (m_data !== prev_data || m_last !== prev_last) begin
            n_fail++;
            $display("FAIL hold bin=%0d data=%h last=%b required %h/%b", idx, m_data, m_last,
                     prev_data, prev_last);
          end
        end
        n_tests++;
        if (m_data !== stim[idx]) begin
          n_fail++;
          $display("FAIL m_data bin=%0d got %h required %h", idx, m_data, stim[idx]);
        end
        n_tests++;
        if (m_last !== 1'(idx == 63)) begin
          n_fail++;
          $display("FAIL m_last bin=%0d got %b required %b", idx, m_last, idx == 63);
        end
        n_tests++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL s_ready_drain bin=%0d got %b required 0", idx, s_ready);
        end
        prev_stall = !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_ready) idx++;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    m_ready = 1'b0;
    n_tests++;
    if (idx < stop_at) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d bins required %0d", idx, stop_at);
    end else if (stop_at == 64) begin
      n_tests++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_drain m_valid=%b s_ready=%b busy=%b required 0/1/0", m_valid,
                 s_ready, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 ||
        s_ready !== 1'b1 || core_x !== '0) begin
      n_fail++;
      $display("FAIL reset_state mv=%b ml=%b fe=%b busy=%b sr=%b cx_nz=%b required 0/0/0/0/1/0",
               m_valid, m_last, frame_err, busy, s_ready, |core_x);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    bit cx_ok = 1'b1;
    for (int i = 0; i < 64; i++) stim[i] = {16'(i), 16'h00A5};
    send_words(64, 63, 1'b0);
    // Edge T0 just passed: m_valid must rise only after edge T0+LAT+1.
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_tests++;
      if (m_valid !== 1'(k == 3)) begin
        n_fail++;
        $display("FAIL ramp_latency edge=T0+%0d m_valid=%b required %b", k, m_valid, k == 3);
      end
    end
    for (int i = 0; i < 64; i++) if (core_x[32*i +: 32] !== stim[i]) cx_ok = 1'b0;
    n_tests++;
    if (!cx_ok || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_core_x match=%b busy=%b required 1/1", cx_ok, busy);
    end
    collect(0, 64);
  endtask

  task automatic test_backpressure();
    fill_random();
    send_words(64, 63, 1'b1);
    collect(1, 64);
  endtask

  task automatic test_early_last();
    int e0, v0;
    e0 = err_cycles;
    v0 = valid_cycles;
    fill_random();
    send_words(10, 9, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (err_cycles - e0 != 1) begin
      n_fail++;
      $display("FAIL early_err_pulse cycles=%0d required 1", err_cycles - e0);
    end
    n_tests++;
    if (valid_cycles != v0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL early_discard mv_cycles=%0d busy=%b s_ready=%b required 0/0/1",
               valid_cycles - v0, busy, s_ready);
    end
    fill_random();
    send_words(64, 63, 1'b0);
    collect(2, 64);
  endtask

  task automatic test_no_last();
    int e0;
    e0 = err_cycles;
    fill_random();
    send_words(64, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (err_cycles - e0 != 1) begin
      n_fail++;
      $display("FAIL nolast_err_pulse cycles=%0d required 1", err_cycles - e0);
    end
    collect(0, 64);
  endtask

  task automatic test_reset_in_drain();
    fill_random();
    send_words(64, 63, 1'b0);
    collect(0, 30);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || core_x !== '0) begin
      n_fail++;
      $display("FAIL drain_reset m_valid=%b busy=%b core_x_nz=%b required 0/0/0", m_valid, busy,
               |core_x);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random();
    send_words(64, 63, 1'b1);
    collect(0, 64);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_words(64, 63, 1'b1);
      collect(2, 64);
    end
  endtask

`ifdef FFTCTL_INV_EN
  task automatic test_inverse();
    fill_random();
    stim[0] = 32'h12345678;
    inv = 1'b1;
    send_words(1, -1, 1'b0);
    inv = 1'b0;  // must be ignored for the rest of the frame
    for (int i = 1; i < 64; i++) begin
      s_valid = 1'b1;
      s_data  = stim[i];
      s_last  = (i == 63);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_tests++;
    if (core_x[31:0] !== 32'h56781234 || core_x[63:32] !== {stim[1][15:0], stim[1][31:16]}) begin
      n_fail++;
      $display("FAIL inv_core_x w0=%h w1=%h required 56781234/%h", core_x[31:0], core_x[63:32],
               {stim[1][15:0], stim[1][31:16]});
    end
    collect(0, 64);
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_early_last();
    test_no_last();
    test_reset_in_drain();
    test_back_to_back();
`ifdef FFTCTL_INV_EN
    test_inverse();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
